// File: rtl/drop_sequencer_pkg.sv
// Shared types and constants for the LED catch game drop sequencer.
// Frame memory is 8 rows of 8 columns; one byte per row.
package drop_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      DRAW,
      WAIT,
      CLEAR,
      JUDGE
   } state_t;

   localparam int         ADDR_W     = 6;
   localparam int         DATA_W     = 8;
   localparam int         ROW_STRIDE = 8;
   localparam logic [2:0] ROW_LAST   = 3'd7;

   function automatic logic [ADDR_W-1:0] row_addr(input logic [2:0] row);
      return ADDR_W'(row) * ADDR_W'(ROW_STRIDE);
   endfunction

   function automatic logic [DATA_W-1:0] col_onehot(input logic [2:0] col);
      return DATA_W'(1) << col;
   endfunction

endpackage

// File: rtl/drop_sequencer_tick.sv
// Drop-step timer: counts while enabled, reports the last cycle of a step.
// Cleared whenever a DRAW write is accepted so every step starts fresh.
module drop_tick_counter #(
   parameter int TICK_DIV = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [7:0] tick_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt <= 8'd0;
      end else if (clear) begin
         tick_cnt <= 8'd0;
      end else if (enable) begin
         tick_cnt <= tick_cnt + 8'd1;
      end
   end

   assign terminal = (tick_cnt == 8'(TICK_DIV - 1));

endmodule

// File: rtl/drop_sequencer.sv
// Game-play controller: spawns a falling LED, steps it down the frame
// memory one row per drop tick, and judges catch/miss against the paddle.
module drop_sequencer
   import drop_sequencer_pkg::*;
#(
   parameter int TICK_DIV = 10,
   parameter int SCORE_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         rand_col,
   input  logic [2:0]         paddle_col,
   output logic               rand_take,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0]  wr_data,
   output logic               hit,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic               busy
);

   state_t     state;
   logic [2:0] row;
   logic [2:0] col;
   logic       stopping;
   logic       accept;
   logic       draw_accept;
   logic       wait_done;

   assign accept      = wr_valid & wr_ready;
   assign draw_accept = (state == DRAW) && accept;
   assign busy        = (state != IDLE);

   drop_tick_counter #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clock    (clock),
      .reset    (reset),
      .clear    (draw_accept),
      .enable   (state == WAIT),
      .terminal (wait_done)
   );

   // Address and data are loaded once when a write is raised and are left
   // alone until the handshake completes, so they stay stable under stall.
   // A stop request seen on leaving WAIT is remembered so the pending
   // clear still happens and the game then parks in IDLE without judging.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         row       <= 3'd0;
         col       <= 3'd0;
         stopping  <= 1'b0;
         score     <= '0;
         rand_take <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         hit       <= 1'b0;
         miss      <= 1'b0;
      end else begin
         rand_take <= 1'b0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  stopping  <= 1'b0;
                  rand_take <= 1'b1;
                  state     <= SPAWN;
               end
            end
            SPAWN: begin
               col      <= rand_col;
               row      <= 3'd0;
               wr_valid <= 1'b1;
               wr_addr  <= row_addr(3'd0);
               wr_data  <= col_onehot(rand_col);
               state    <= DRAW;
            end
            DRAW: begin
               if (accept) begin
                  wr_valid <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_done) begin
                  stopping <= ~start;
                  wr_valid <= 1'b1;
                  wr_data  <= '0;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               if (accept) begin
                  if (stopping) begin
                     wr_valid <= 1'b0;
                     state    <= IDLE;
                  end else if (row == ROW_LAST) begin
                     wr_valid <= 1'b0;
                     state    <= JUDGE;
                  end else begin
                     row      <= row + 3'd1;
                     wr_addr  <= row_addr(row + 3'd1);
                     wr_data  <= col_onehot(col);
                     state    <= DRAW;
                  end
               end
            end
            JUDGE: begin
               if (paddle_col == col) begin
                  hit <= 1'b1;
                  if (score != '1) begin
                     score <= score + SCORE_W'(1);
                  end
               end else begin
                  miss <= 1'b1;
               end
               if (start) begin
                  rand_take <= 1'b1;
                  state     <= SPAWN;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer: a write scoreboard fed per game,
// a table of catch/miss games, and hand sequences for stall/stop/saturate/reset.
module tb_drop_sequencer;

   localparam int TICK_DIV = 4;
   localparam int SCORE_W  = 8;

   logic               clock = 1'b0;
   logic               reset;
   logic               start;
   logic [2:0]         rand_col;
   logic [2:0]         paddle_col;
   logic               rand_take;
   logic               wr_valid;
   logic               wr_ready;
   logic [5:0]         wr_addr;
   logic [7:0]         wr_data;
   logic               hit;
   logic               miss;
   logic [SCORE_W-1:0] score;
   logic               busy;

   typedef struct {
      logic [5:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic [2:0] rc;
      logic [2:0] pc;
      logic       exp_hit;
      logic [7:0] exp_score;
   } vec_t;

   wr_t        exp_q[$];
   wr_t        exp_w;
   vec_t       vecs[5];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         draw_cyc = 0;
   bit         have_draw = 1'b0;
   logic [7:0] model_score = 8'd0;

   drop_sequencer #(
      .TICK_DIV (TICK_DIV),
      .SCORE_W  (SCORE_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .rand_col   (rand_col),
      .paddle_col (paddle_col),
      .rand_take  (rand_take),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .hit        (hit),
      .miss       (miss),
      .score      (score),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual %0h, required %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] rc, input logic [2:0] pc, input logic st, input logic rdy);
      rand_col   = rc;
      paddle_col = pc;
      start      = st;
      wr_ready   = rdy;
   endtask

   task automatic pushGame(input logic [2:0] rc, input int last_row);
      wr_t w;
      for (int r = 0; r <= last_row; r++) begin
         w.addr = 6'(r * 8);
         w.data = 8'h01 << rc;
         exp_q.push_back(w);
         w.data = 8'h00;
         exp_q.push_back(w);
      end
   endtask

   // Scoreboard: every accepted write is matched against the queue, and each
   // clear must follow its draw by exactly the drop interval plus one.
   always @(negedge clock) begin
      if (!reset && wr_valid && wr_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: actual addr %0d data %02h, required no write", wr_addr, wr_data);
         end else begin
            exp_w = exp_q.pop_front();
            checkOutput("wr_addr", 32'(wr_addr), 32'(exp_w.addr));
            checkOutput("wr_data", 32'(wr_data), 32'(exp_w.data));
         end
         if (wr_data != 8'h00) begin
            draw_cyc  = cyc;
            have_draw = 1'b1;
         end else if (have_draw) begin
            checkOutput("tick_interval", 32'(cyc - draw_cyc), 32'(TICK_DIV + 1));
            have_draw = 1'b0;
         end
      end
   end

   // Plays one full drop; entered at a negedge. stall_row > 0 holds ready low
   // for three cycles during that row's draw; last drops start before JUDGE.
   task automatic runGame(input logic [2:0] rc, input logic [2:0] pc, input logic exp_hit,
                          input logic [7:0] exp_score, input bit last, input int stall_row);
      int n;
      bit stalled;
      stalled    = 1'b0;
      rand_col   = rc;
      paddle_col = pc;
      start      = 1'b1;
      pushGame(rc, 7);
      n = 0;
      while (!rand_take && n < 50) begin
         @(negedge clock);
         n++;
      end
      checkOutput("rand_take", 32'(rand_take), 32'd1);
      @(negedge clock);
      n = 0;
      while (!(hit || miss) && n < 300) begin
         if (last && wr_valid && wr_addr == 6'd56 && wr_data == 8'h00) start = 1'b0;
         if (stall_row > 0 && !stalled && wr_valid && wr_data == 8'h00 &&
             wr_addr == 6'((stall_row - 1) * 8)) begin
            stalled = 1'b1;
            @(posedge clock);
            #1 wr_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clock);
               checkOutput("stall_valid", 32'(wr_valid), 32'd1);
               checkOutput("stall_addr", 32'(wr_addr), 32'(stall_row * 8));
               checkOutput("stall_data", 32'(wr_data), 32'(8'h01 << rc));
            end
            @(posedge clock);
            #1 wr_ready = 1'b1;
         end
         @(negedge clock);
         n++;
      end
      checkOutput("hit", 32'(hit), 32'(exp_hit));
      checkOutput("miss", 32'(miss), 32'(!exp_hit));
      checkOutput("score", 32'(score), 32'(exp_score));
   endtask

   initial begin
      int  n;
      bit  saw_pulse;

      vecs[0] = '{rc: 3'd5, pc: 3'd5, exp_hit: 1'b1, exp_score: 8'd1};
      vecs[1] = '{rc: 3'd5, pc: 3'd2, exp_hit: 1'b0, exp_score: 8'd1};
      vecs[2] = '{rc: 3'd0, pc: 3'd0, exp_hit: 1'b1, exp_score: 8'd2};
      vecs[3] = '{rc: 3'd7, pc: 3'd6, exp_hit: 1'b0, exp_score: 8'd2};
      vecs[4] = '{rc: 3'd7, pc: 3'd7, exp_hit: 1'b1, exp_score: 8'd3};

      reset = 1'b1;
      applyStimulus(3'd0, 3'd0, 1'b0, 1'b1);
      @(negedge clock);
      checkOutput("reset_valid", 32'(wr_valid), 32'd0);
      checkOutput("reset_addr", 32'(wr_addr), 32'd0);
      checkOutput("reset_data", 32'(wr_data), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_take", 32'(rand_take), 32'd0);
      checkOutput("reset_hitmiss", 32'({hit, miss}), 32'd0);
      checkOutput("reset_score", 32'(score), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      $display("[TB] table of catch/miss games");
      for (int i = 0; i < 5; i++) begin
         runGame(vecs[i].rc, vecs[i].pc, vecs[i].exp_hit, vecs[i].exp_score, 1'b1, 0);
         checkOutput("idle_after_game", 32'(busy), 32'd0);
      end
      model_score = 8'd3;

      $display("[TB] ready stall during row 3 draw");
      model_score = model_score + 8'd1;
      runGame(3'd6, 3'd6, 1'b1, model_score, 1'b1, 3);

      $display("[TB] stop during row 4 wait");
      @(negedge clock);
      pushGame(3'd1, 4);
      applyStimulus(3'd1, 3'd1, 1'b1, 1'b1);
      n = 0;
      while (!(wr_valid && wr_addr == 6'd32 && wr_data != 8'h00) && n < 300) begin
         @(negedge clock);
         n++;
      end
      checkOutput("row4_draw_seen", 32'(wr_valid), 32'd1);
      @(negedge clock);
      start = 1'b0;
      saw_pulse = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         saw_pulse |= (hit | miss);
         @(negedge clock);
         n++;
      end
      saw_pulse |= (hit | miss);
      checkOutput("stop_busy", 32'(busy), 32'd0);
      checkOutput("stop_no_judge", 32'(saw_pulse), 32'd0);
      checkOutput("stop_writes_done", 32'(exp_q.size()), 32'd0);
      checkOutput("stop_score", 32'(score), 32'(model_score));

      $display("[TB] back-to-back catches up to saturation");
      @(negedge clock);
      while (model_score != 8'hFF) begin
         model_score = model_score + 8'd1;
         runGame(model_score[2:0], model_score[2:0], 1'b1, model_score, 1'b0, 0);
      end
      runGame(3'd4, 3'd4, 1'b1, 8'hFF, 1'b1, 0);

      $display("[TB] reset during a clear write");
      @(negedge clock);
      exp_w.addr = 6'd0;
      exp_w.data = 8'h08;
      exp_q.push_back(exp_w);
      applyStimulus(3'd3, 3'd0, 1'b1, 1'b1);
      n = 0;
      while (!(wr_valid && wr_data != 8'h00) && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkOutput("rst_draw_seen", 32'(wr_valid), 32'd1);
      @(posedge clock);
      #1 wr_ready = 1'b0;
      n = 0;
      while (!wr_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkOutput("rst_clear_pending", 32'(wr_valid), 32'd1);
      reset = 1'b1;
      start = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(wr_valid), 32'd0);
      checkOutput("rst_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_data", 32'(wr_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_score", 32'(score), 32'd0);
      checkOutput("rst_pulses", 32'({rand_take, hit, miss}), 32'd0);
      @(negedge clock);
      reset    = 1'b0;
      wr_ready = 1'b1;
      repeat (5) @(negedge clock);
      checkOutput("post_rst_idle", 32'(busy), 32'd0);
      checkOutput("post_rst_no_write", 32'(wr_valid), 32'd0);
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
Game-play controller for the LED catch game. It samples the random column, spawns a falling LED at row 0, and steps it down one row per drop tick. It writes draw and clear bytes into the 64-byte LED frame memory through a valid/ready write port, and judges catch or miss against the paddle column when the LED reaches row 7. It sits between the RNG / bit-selector datapath and the frame memory.

Parameters:
TICK_DIV, 10, clock cycles per drop step; legal range 2..255.
SCORE_W, 8, score counter width.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; 1 = run game, 0 = stop after the current write
rand_col  in  3  random column from RNG (rand1)
paddle_col  in  3  current paddle column
rand_take  out  1  one-cycle pulse when rand_col is sampled
wr_valid  out  1  frame-memory write request
wr_ready  in  1  frame memory accepts the write this cycle
wr_addr  out  6  byte address = row*8 (0,8,...,56)
wr_data  out  8  one-hot column byte, or 0 for clear
hit  out  1  one-cycle pulse on catch
miss  out  1  one-cycle pulse on miss
score  out  SCORE_W  catch count, saturating
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, row=0, col=0, tick_cnt=0, score=0; all outputs 0.
- States: IDLE, SPAWN, DRAW, WAIT, CLEAR, JUDGE.
- IDLE -> SPAWN when start=1.
- SPAWN (1 cycle):
  - col <= rand_col, row <= 0, rand_take=1.
  - Go to DRAW.
- DRAW:
  - wr_valid=1, wr_addr={row,3'b000}, wr_data=1<<col.
  - Hold all three stable until wr_ready=1. The transfer occurs on the cycle valid&ready are both high.
  - Then tick_cnt <= 0 and go to WAIT.
- WAIT:
  - tick_cnt increments every cycle.
  - When tick_cnt==TICK_DIV-1, go to CLEAR. DRAW-accept to CLEAR entry is exactly TICK_DIV cycles.
- CLEAR:
  - wr_valid=1, wr_addr={row,3'b000}, wr_data=0; hold until wr_ready.
  - On accept: if row==7, go to JUDGE; else row <= row+1 and go to DRAW.
- JUDGE (1 cycle):
  - If paddle_col==col: hit=1 and score <= score+1, saturating at all ones.
  - Otherwise miss=1.
  - Then go to SPAWN if start=1, else IDLE.
- Stop handling:
  - start=0 is sampled only on leaving WAIT or JUDGE.
  - From WAIT, the controller still performs CLEAR, then goes to IDLE without judging. This leaves no LED lit.
  - start=0 never aborts a write mid-handshake.
- wr_valid is never dropped before acceptance. Address and data never change while wr_valid=1 and wr_ready=0.
- wr_ready while wr_valid=0 is ignored.
- score persists across stop/start; only reset clears it.
- Reset mid-write: wr_valid goes to 0 immediately (asynchronous); the frame memory is left as-is.
- Row wrap: row never exceeds 7. Address arithmetic is 6 bits, with no overflow.

Decomposition:
- Shared package holds:
  - the state enum (IDLE..JUDGE);
  - ROW_LAST=3'd7;
  - the ROW_STRIDE=8 constant shared with the address selector;
  - the frame-address width 6 and data width 8.
- One natural sub-module: drop_tick_counter (TICK_DIV counter with clear and terminal-count output).
- The FSM and score counter stay in the top block.

Test Plan:
1. Reset, then start=1, rand_col=5, wr_ready=1 always, TICK_DIV=4.
   - rand_take pulse, then write (addr 0, data 0x20).
   - 4 cycles later write (0, 0x00), then write (8, 0x20).
   - Pattern repeats through addr 56.
2. Same as 1 with paddle_col=5 at JUDGE -> hit pulse, score 0->1, next SPAWN. With paddle_col=2 instead -> miss pulse, score unchanged.
3. wr_ready held 0 for 3 cycles during DRAW row 3 -> wr_valid, addr 24 and data stay stable. WAIT starts only after the ready cycle; the tick interval is still 4.
4. Drop start to 0 during WAIT at row 4 -> clear write to addr 32 with data 0, then IDLE, busy=0, no hit/miss.
5. Preload score to 255 (SCORE_W=8) via 255 catches, or force -> further catch keeps score 255 while the hit pulse still asserts.
6. Assert reset while wr_valid=1 in CLEAR -> all outputs 0 in the same cycle; after release, IDLE until start.
